// File: rtl/regfile_scoreboard_if.sv
// Issue/read/write-back bundle between the decode/write-back pipeline (master)
// and the register file with its busy scoreboard (slave).
interface regfile_scoreboard_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_READ   = 2
);
  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_READ*DATA_WIDTH-1:0] rd_data;
  logic [NUM_READ-1:0]            rd_busy;
  logic                           issue_valid;
  logic [NUM_READ-1:0]            issue_use;
  logic                           issue_rd_en;
  logic [ADDR_WIDTH-1:0]          issue_rd;
  logic                           issue_stall;
  logic                           wen;
  logic [ADDR_WIDTH-1:0]          waddr;
  logic [DATA_WIDTH-1:0]          wdata;
  logic                           flush;
  logic [ADDR_WIDTH-1:0]          dbg_addr;
  logic [DATA_WIDTH-1:0]          dbg_data;
  logic [(1<<ADDR_WIDTH)-1:0]     busy_vec;

  modport master (
    output rd_addr, issue_valid, issue_use, issue_rd_en, issue_rd,
           wen, waddr, wdata, flush, dbg_addr,
    input  rd_data, rd_busy, issue_stall, dbg_data, busy_vec
  );

  modport slave (
    input  rd_addr, issue_valid, issue_use, issue_rd_en, issue_rd,
           wen, waddr, wdata, flush, dbg_addr,
    output rd_data, rd_busy, issue_stall, dbg_data, busy_vec
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Integer register file with NUM_READ combinational read ports, one write-back
// port and a per-register busy scoreboard. Optional: REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_scoreboard_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DEPTH-1:0][DATA_WIDTH-1:0]    rf;
  logic [DEPTH-1:0]                    busy;
  logic [NUM_READ-1:0][DATA_WIDTH-1:0] rd_data;
  logic [NUM_READ-1:0]                 rd_busy;
  logic                                wr_ok;
  logic                                dst_hit;
  logic                                dst_busy;
  logic                                stall;
  logic                                fire;

  function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign wr_ok = bus.wen && !is_zero(bus.waddr);

  // Per-port read: a bypass hit forwards wdata and hides the pending busy bit
  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic                  hit;
    assign ra         = bus.rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign hit        = BYPASS && wr_ok && (ra == bus.waddr);
    assign rd_data[k] = is_zero(ra) ? '0 : (hit ? bus.wdata : rf[ra]);
    assign rd_busy[k] = !is_zero(ra) && busy[ra] && !hit;
  end

  assign dst_hit  = BYPASS && wr_ok && (bus.issue_rd == bus.waddr);
  assign dst_busy = !is_zero(bus.issue_rd) && busy[bus.issue_rd] && !dst_hit;
  assign stall    = bus.issue_valid &&
                    ((|(bus.issue_use & rd_busy)) || (bus.issue_rd_en && dst_busy));
  assign fire     = bus.issue_valid && !stall && bus.issue_rd_en && !bus.flush &&
                    !is_zero(bus.issue_rd);

  assign bus.rd_data     = rd_data;
  assign bus.rd_busy     = rd_busy;
  assign bus.issue_stall = stall;
  assign bus.dbg_data    = is_zero(bus.dbg_addr) ? '0 : rf[bus.dbg_addr];
  assign bus.busy_vec    = busy;

  // Data commits even in a flush cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rf <= '0;
    else if (wr_ok) rf[bus.waddr] <= bus.wdata;
  end

  // Set is applied after clear so a younger producer wins on the same index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else if (bus.flush) busy <= '0;
    else begin
      if (wr_ok) busy[bus.waddr] <= 1'b0;
      if (fire)  busy[bus.issue_rd] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized plus directed bench for regfile_scoreboard against an array/flag
// reference model; follows REGFILE_BYPASS_EN when the build defines it.
module tb_regfile_scoreboard;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int NREG = 1 << AW;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_scoreboard_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR)) bus ();

  regfile_scoreboard #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  logic [DW-1:0] rf_m [NREG];
  bit            busy_m [NREG];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit byp_hit(input int a);
    return BYP && bus.wen && (bus.waddr != 0) && (int'(bus.waddr) == a);
  endfunction

  function automatic logic [DW-1:0] exp_rd(input int a);
    if (a == 0) return '0;
    if (byp_hit(a)) return bus.wdata;
    return rf_m[a];
  endfunction

  function automatic bit exp_busy(input int a);
    return (a != 0) && busy_m[a] && !byp_hit(a);
  endfunction

  function automatic bit exp_stall();
    bit s = 1'b0;
    if (!bus.issue_valid) return 1'b0;
    for (int k = 0; k < NR; k++)
      if (bus.issue_use[k] && exp_busy(int'(bus.rd_addr[k*AW +: AW]))) s = 1'b1;
    if (bus.issue_rd_en && exp_busy(int'(bus.issue_rd))) s = 1'b1;
    return s;
  endfunction

  function automatic logic [NREG-1:0] exp_bv();
    logic [NREG-1:0] v;
    for (int i = 0; i < NREG; i++) v[i] = busy_m[i];
    return v;
  endfunction

  task automatic compare_all();
    for (int k = 0; k < NR; k++) begin
      chk("rd_data", 64'(bus.rd_data[k*DW +: DW]), 64'(exp_rd(int'(bus.rd_addr[k*AW +: AW]))));
      chk("rd_busy", 64'(bus.rd_busy[k]), 64'(exp_busy(int'(bus.rd_addr[k*AW +: AW]))));
    end
    chk("issue_stall", 64'(bus.issue_stall), 64'(exp_stall()));
    chk("dbg_data", 64'(bus.dbg_data), 64'((bus.dbg_addr == 0) ? '0 : rf_m[bus.dbg_addr]));
    chk("busy_vec", 64'(bus.busy_vec), 64'(exp_bv()));
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      rf_m[i] = '0;
      busy_m[i] = 1'b0;
    end
  endtask

  // Clock-edge behaviour from the rules: data write, flush, clear, then set
  task automatic model_update(input bit stall);
    bit fire;
    fire = bus.issue_valid && !stall && bus.issue_rd_en && !bus.flush;
    if (bus.wen && bus.waddr != 0) rf_m[bus.waddr] = bus.wdata;
    if (bus.flush) begin
      for (int i = 0; i < NREG; i++) busy_m[i] = 1'b0;
    end else begin
      if (bus.wen) busy_m[bus.waddr] = 1'b0;
      if (fire && bus.issue_rd != 0) busy_m[bus.issue_rd] = 1'b1;
    end
  endtask

  task automatic tick();
    bit s;
    #1 compare_all();
    s = exp_stall();
    @(posedge clk);
    model_update(s);
    #1;
  endtask

  task automatic idle();
    bus.rd_addr = '0; bus.issue_valid = 0; bus.issue_use = '0; bus.issue_rd_en = 0;
    bus.issue_rd = '0; bus.wen = 0; bus.waddr = '0; bus.wdata = '0; bus.flush = 0;
    bus.dbg_addr = '0;
  endtask

  task automatic issue_dst(input int r);
    idle();
    bus.issue_valid = 1; bus.issue_rd_en = 1; bus.issue_rd = AW'(r);
    tick();
  endtask

  task automatic rd_port(input int k, input int a);
    bus.rd_addr[k*AW +: AW] = AW'(a);
  endtask

  initial begin
    idle();
    model_reset();
    #12 rst_n = 1'b1;
    #1 compare_all();
    chk("reset_busy_vec", 64'(bus.busy_vec), 64'h0);
    @(posedge clk); #1;

    // Every index on every port reads zero after reset
    for (int i = 0; i < NREG; i++) begin
      rd_port(0, i); rd_port(1, NREG-1-i); bus.dbg_addr = AW'(i);
      tick();
    end

    idle(); bus.wen = 1; bus.waddr = 5; bus.wdata = 32'hDEADBEEF; tick();
    idle(); rd_port(0, 5); bus.dbg_addr = 5;
    #1 chk("x5_rd", 64'(bus.rd_data[DW-1:0]), 64'hDEADBEEF);
    chk("x5_dbg", 64'(bus.dbg_data), 64'hDEADBEEF);
    tick();

    // Zero register ignores writes and never becomes busy
    idle(); bus.wen = 1; bus.waddr = 0; bus.wdata = 32'h1234; tick();
    idle(); bus.issue_valid = 1; bus.issue_rd_en = 1; bus.issue_rd = 0;
    #1 chk("x0_rd", 64'(bus.rd_data[DW-1:0]), 64'h0);
    chk("x0_issue_stall", 64'(bus.issue_stall), 64'h0);
    tick();
    chk("x0_busy", 64'(bus.busy_vec[0]), 64'h0);

    // RAW on x3
    issue_dst(3);
    idle(); bus.issue_valid = 1; bus.issue_use = 2'b01; rd_port(0, 3);
    #1 chk("raw_stall", 64'(bus.issue_stall), 64'h1);
    tick();
    bus.wen = 1; bus.waddr = 3; bus.wdata = 32'h55;
    #1 chk("raw_wb_stall", 64'(bus.issue_stall), BYP ? 64'h0 : 64'h1);
    if (BYP) chk("raw_wb_bypass", 64'(bus.rd_data[DW-1:0]), 64'h55);
    tick();
    bus.wen = 0;
    #1 chk("raw_after_stall", 64'(bus.issue_stall), 64'h0);
    chk("raw_after_rd", 64'(bus.rd_data[DW-1:0]), 64'h55);
    tick();

    // WAW with same-cycle clear and set on x7
    issue_dst(7);
    idle(); bus.wen = 1; bus.waddr = 7; bus.wdata = 32'h77;
    bus.issue_valid = 1; bus.issue_rd_en = 1; bus.issue_rd = 7;
    tick();
    idle();
    chk("waw_busy7", 64'(bus.busy_vec[7]), BYP ? 64'h1 : 64'h0);
    bus.dbg_addr = 7;
    #1 chk("waw_rf7", 64'(bus.dbg_data), 64'h77);
    tick();
    if (!BYP) begin
      bus.wen = 1; bus.waddr = 7; bus.wdata = 32'h77; tick();
    end
    idle(); bus.wen = 1; bus.waddr = 7; bus.wdata = 32'h77; tick();

    // Flush beats a same-cycle issue; the write still lands
    issue_dst(2); issue_dst(9); issue_dst(10);
    idle(); bus.flush = 1; bus.issue_valid = 1; bus.issue_rd_en = 1; bus.issue_rd = 4;
    bus.wen = 1; bus.waddr = 9; bus.wdata = 32'hA5;
    tick();
    idle();
    chk("flush_busy_vec", 64'(bus.busy_vec), 64'h0);
    bus.dbg_addr = 9;
    #1 chk("flush_x9", 64'(bus.dbg_data), 64'hA5);
    tick();

    // Randomized traffic, addresses biased low to provoke hazards
    for (int n = 0; n < 800; n++) begin
      for (int k = 0; k < NR; k++)
        rd_port(k, ($urandom_range(0, 3) == 0) ? $urandom_range(0, NREG-1) : $urandom_range(0, 7));
      bus.issue_valid = ($urandom_range(0, 9) < 7);
      bus.issue_use   = NR'($urandom);
      bus.issue_rd_en = $urandom_range(0, 1);
      bus.issue_rd    = AW'($urandom_range(0, 7));
      bus.wen         = ($urandom_range(0, 2) != 0);
      bus.waddr       = AW'($urandom_range(0, 7));
      bus.wdata       = $urandom;
      bus.flush       = ($urandom_range(0, 19) == 0);
      bus.dbg_addr    = AW'($urandom_range(0, 7));
      tick();
    end

    // Asynchronous reset mid-cycle with state present
    issue_dst(6);
    idle(); bus.wen = 1; bus.waddr = 12; bus.wdata = 32'hCAFE; tick();
    idle(); rd_port(0, 12); rd_port(1, 6); bus.dbg_addr = 12;
    bus.issue_valid = 1; bus.issue_use = 2'b10;
    #2 rst_n = 1'b0;
    #1 chk("arst_busy_vec", 64'(bus.busy_vec), 64'h0);
    chk("arst_rd0", 64'(bus.rd_data[DW-1:0]), 64'h0);
    chk("arst_rd_busy", 64'(bus.rd_busy), 64'h0);
    chk("arst_stall", 64'(bus.issue_stall), 64'h0);
    chk("arst_dbg", 64'(bus.dbg_data), 64'h0);
    model_reset();
    idle();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    bus.dbg_addr = 12; tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the NPC integer register file.
- Provides NUM_READ combinational read ports, one write-back port and a per-register busy scoreboard.
- The scoreboard is set at instruction issue and cleared at write-back, and it drives an issue stall on RAW/WAW hazards.
- Sits between decode/issue and write-back in the pipelined core; a dedicated debug read port serves difftest.

Parameters:
ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
DATA_WIDTH, 32, register data width
NUM_READ, 2, number of read (source operand) ports, 1..4
ZERO_REG, 1, 1 = register 0 hardwired to zero and never marked busy; 0 = register 0 is ordinary

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
rd_addr  input  NUM_READ*ADDR_WIDTH  packed read addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
rd_data  output  NUM_READ*DATA_WIDTH  packed read data, combinational
rd_busy  output  NUM_READ  per-port: addressed register has a pending write
issue_valid  input  1  decode presents an instruction
issue_use  input  NUM_READ  per-port: operand k is actually used by this instruction
issue_rd_en  input  1  instruction writes a destination
issue_rd  input  ADDR_WIDTH  destination register index
issue_stall  output  1  instruction must not issue this cycle
wen  input  1  write-back valid
waddr  input  ADDR_WIDTH  write-back register index
wdata  input  DATA_WIDTH  write-back data
flush  input  1  pipeline flush; clears all busy bits
dbg_addr  input  ADDR_WIDTH  debug/difftest read index
dbg_data  output  DATA_WIDTH  debug read data, combinational, never bypassed
busy_vec  output  2**ADDR_WIDTH  raw scoreboard state

Behaviour:
- Reset (rst_n low, async): all registers = 0; all busy bits = 0. Outputs are then rd_data = 0, rd_busy = 0, issue_stall = 0 (since busy = 0), dbg_data = 0, busy_vec = 0.
- Reset mid-operation discards pending busy state. After deassertion, normal operation resumes on the first rising edge.
- Zero rule (ZERO_REG=1):
  - Reads of index 0 return 0 and rd_busy = 0.
  - Writes to index 0 are dropped.
  - issue_rd = 0 never sets busy.
- Write: on the rising edge with wen=1 and waddr not the zero register, rf[waddr] <= wdata.
  - A write to a non-busy register is legal: data is written, scoreboard unchanged.
- Read: rd_data[k] = rf[rd_addr[k]], combinational, zero-latency; bypass per the optional feature.
- Scoreboard next state, priority highest first:
  1. flush=1: all busy <= 0; issue ignored; a same-cycle write still commits data.
  2. wen=1: busy[waddr] <= 0.
  3. issue_fire: busy[issue_rd] <= 1.
  - If clear and set target the same index in the same cycle, set wins (the new producer is younger).
- issue_fire = issue_valid & !issue_stall & issue_rd_en & !flush.
- issue_stall = issue_valid & (OR over k of (issue_use[k] & rd_busy[k]) | (issue_rd_en & eff_busy[issue_rd])). This covers RAW on used operands and WAW on the destination.
- eff_busy[i] = busy[i], except as modified by the optional feature.
- issue_stall = 0 whenever issue_valid = 0.
- Unused operands (issue_use[k] = 0) never stall, even if busy.
- dbg_data = rf[dbg_addr] (array value, 0 for the zero register); it never reflects in-flight wdata.

Optional Feature:
REGFILE_BYPASS_EN
- Defined:
  - When wen=1 and rd_addr[k]==waddr (not the zero register), rd_data[k] = wdata.
  - eff_busy[waddr] and rd_busy[k] are treated as 0 in that cycle, so a dependent instruction issues in the write-back cycle.
  - If issue_fire targets the same index, the set still wins for the next cycle.
- Undefined:
  - Reads return the pre-write array value.
  - rd_busy/eff_busy reflect busy as stored, so a dependent instruction stalls one extra cycle and issues the cycle after write-back.

Test Plan:
- Reset then read all ports at indices 0..31 -> rd_data = 0, busy_vec = 0. Write x5 = 0xDEADBEEF -> next cycle rd_data[0] = 0xDEADBEEF at rd_addr = 5, dbg_addr = 5 gives the same value.
- wen=1, waddr=0, wdata=0x1234 -> x0 still reads 0. issue_rd=0 with issue_valid -> busy_vec[0] stays 0, issue_stall=0.
- RAW: issue rd=x3, next cycle issue reading x3 with issue_use[0]=1 -> issue_stall=1.
  - Write-back x3 = 0x55: with REGFILE_BYPASS_EN, stall drops in the write-back cycle and rd_data[0] = 0x55.
  - Without REGFILE_BYPASS_EN, stall drops one cycle later.
- WAW plus same-index set/clear: busy x7; in one cycle wen to x7 and issue_rd=x7 (bypass build) -> busy_vec[7] = 1 next cycle, rf[7] = wdata.
- flush with x2, x9, x10 busy and a simultaneous issue to x4 -> busy_vec = 0 next cycle, x4 not busy; a same-cycle wen to x9 = 0xA5 commits data.
- Assert rst_n=0 asynchronously mid-cycle with busy bits set and nonzero registers -> outputs and busy_vec go to 0 before the next clock edge.
